// File: rtl/hazard_scheduler.sv
// Scoreboard-based hazard scheduler for a non-forwarding 5-stage pipeline.
//
// Tracks in-flight register writes with one down-counter per architectural
// register and raises RAW stalls on the ID-stage sources. It also sequences
// control flushes after an EX-stage redirect.
//
// Optional feature macro: HAZARD_STALL_STATS_EN adds the stall statistics
// counters data_stall_cnt_o / ctrl_stall_cnt_o.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   id_valid_i       ID stage holds a valid instruction
//   id_rs1_i/_use_i  ID source 1 and its read enable
//   id_rs2_i/_use_i  ID source 2 and its read enable
//   id_rd_i          ID destination register
//   id_rd_wren_i     instruction writes rd
//   ex_redirect_i    EX redirected the PC this cycle
//   hazard_op_o      0 none, 1 data stall, 2 control flush
//   issue_o          ID instruction advances into EX this cycle
//   busy_o           at least one scoreboard entry is non-zero
//   data_stall_cnt_o cycles with hazard_op_o==1 (HAZARD_STALL_STATS_EN only)
//   ctrl_stall_cnt_o cycles with hazard_op_o==2 (HAZARD_STALL_STATS_EN only)
module hazard_scheduler #(
  parameter int unsigned WB_DIST      = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned RF_WR_FIRST  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic        id_rs1_use_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs2_use_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rd_wren_i,
  input  logic        ex_redirect_i,
  output logic [1:0]  hazard_op_o,
  output logic        issue_o,
`ifdef HAZARD_STALL_STATS_EN
  output logic [31:0] data_stall_cnt_o,
  output logic [31:0] ctrl_stall_cnt_o,
`endif
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(WB_DIST + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(WB_DIST);
  // With write-before-read RF, a producer one cycle from WB is already readable.
  localparam logic [CntW-1:0] Thresh = CntW'(RF_WR_FIRST != 0);
  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDstall, StFlush} state_e;

  state_e          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [CntW-1:0] sb_q [32];
  logic [CntW-1:0] sb_d [32];

  logic rs1_haz, rs2_haz, data_haz, any_busy;

  // Zero-cycle RAW detection on the ID operands; x0 is never a hazard.
  assign rs1_haz  = id_rs1_use_i && (id_rs1_i != 5'd0) && (sb_q[id_rs1_i] > Thresh);
  assign rs2_haz  = id_rs2_use_i && (id_rs2_i != 5'd0) && (sb_q[id_rs2_i] > Thresh);
  assign data_haz = id_valid_i && (rs1_haz || rs2_haz);

  always_comb begin
    any_busy = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (sb_q[i] != '0) any_busy = 1'b1;
    end
  end

  // Control beats data; outputs are forced quiet while reset is asserted.
  always_comb begin
    hazard_op_o = 2'd0;
    if (!rst_i) begin
      if (state_q == StFlush || ex_redirect_i) begin
        hazard_op_o = 2'd2;
      end else if (data_haz) begin
        hazard_op_o = 2'd1;
      end
    end
  end

  assign issue_o = !rst_i && id_valid_i && (hazard_op_o == 2'd0);
  assign busy_o  = !rst_i && any_busy;

  // Load on issue overrides the per-cycle decrement.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sb_d[i] = (sb_q[i] != '0) ? sb_q[i] - 1'b1 : '0;
      if (i != 0 && issue_o && id_rd_wren_i && id_rd_i == 5'(i)) begin
        sb_d[i] = LoadVal;
      end
    end
    sb_d[0] = '0;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StRun, StDstall: begin
        if (ex_redirect_i) begin
          flush_cnt_d = FlushInit;
          state_d     = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (data_haz) begin
          state_d = StDstall;
        end else begin
          state_d = StRun;
        end
      end
      StFlush: begin
        if (ex_redirect_i) begin
          flush_cnt_d = FlushInit;
          state_d     = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else begin
          flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
          if (flush_cnt_q <= 3'd1) state_d = StRun;
        end
      end
      default: begin
        state_d     = StRun;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      flush_cnt_q <= 3'd0;
      for (int i = 0; i < 32; i++) sb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] data_cnt_q, ctrl_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_cnt_q <= 32'd0;
      ctrl_cnt_q <= 32'd0;
    end else begin
      if (hazard_op_o == 2'd1) data_cnt_q <= data_cnt_q + 32'd1;
      if (hazard_op_o == 2'd2) ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
    end
  end

  assign data_stall_cnt_o = data_cnt_q;
  assign ctrl_stall_cnt_o = ctrl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_use, rs2_use, wren, redir;

  logic [1:0] op0, op1, op2;
  logic       iss0, iss1, iss2;
  logic       busy0, busy1, busy2;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] dcnt0, ccnt0, dcnt1, ccnt1, dcnt2, ccnt2;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // dut0: defaults. dut1: RF not write-first. dut2: two-cycle flush.
  hazard_scheduler dut0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
    .id_rs1_i(rs1), .id_rs1_use_i(rs1_use), .id_rs2_i(rs2), .id_rs2_use_i(rs2_use),
    .id_rd_i(rd), .id_rd_wren_i(wren), .ex_redirect_i(redir),
    .hazard_op_o(op0), .issue_o(iss0),
`ifdef HAZARD_STALL_STATS_EN
    .data_stall_cnt_o(dcnt0), .ctrl_stall_cnt_o(ccnt0),
`endif
    .busy_o(busy0)
  );

  hazard_scheduler #(.RF_WR_FIRST(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
    .id_rs1_i(rs1), .id_rs1_use_i(rs1_use), .id_rs2_i(rs2), .id_rs2_use_i(rs2_use),
    .id_rd_i(rd), .id_rd_wren_i(wren), .ex_redirect_i(redir),
    .hazard_op_o(op1), .issue_o(iss1),
`ifdef HAZARD_STALL_STATS_EN
    .data_stall_cnt_o(dcnt1), .ctrl_stall_cnt_o(ccnt1),
`endif
    .busy_o(busy1)
  );

  hazard_scheduler #(.FLUSH_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid),
    .id_rs1_i(rs1), .id_rs1_use_i(rs1_use), .id_rs2_i(rs2), .id_rs2_use_i(rs2_use),
    .id_rd_i(rd), .id_rd_wren_i(wren), .ex_redirect_i(redir),
    .hazard_op_o(op2), .issue_o(iss2),
`ifdef HAZARD_STALL_STATS_EN
    .data_stall_cnt_o(dcnt2), .ctrl_stall_cnt_o(ccnt2),
`endif
    .busy_o(busy2)
  );

  typedef struct {
    logic       rst, valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wren, redir;
    logic [1:0] op;
    logic       issue, busy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic r, logic v, logic [4:0] a, logic ua, logic [4:0] b,
                              logic ub, logic [4:0] d, logic w, logic x,
                              logic [1:0] eo, logic ei, logic eb);
    vec_t t;
    t.rst = r; t.valid = v; t.rs1 = a; t.u1 = ua; t.rs2 = b; t.u2 = ub;
    t.rd = d; t.wren = w; t.redir = x; t.op = eo; t.issue = ei; t.busy = eb;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic [4:0] d,
                       input logic w, input logic x);
    rst = r; valid = v; rs1 = a; rs1_use = ua; rs2 = b; rs2_use = ub;
    rd = d; wren = w; redir = x;
  endtask

  // Inputs change 1 after posedge; outputs sampled at the following negedge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //             rst v rs1 u rs2 u rd w x   op iss busy
    vecs[0]  = mk(1, 1, 0,  0, 0,  0, 5, 1, 0, 0, 0, 0); // reset suppresses issue
    vecs[1]  = mk(0, 1, 1,  1, 0,  0, 5, 1, 0, 0, 1, 0); // producer x5
    vecs[2]  = mk(0, 1, 5,  1, 0,  0, 6, 1, 0, 1, 0, 1); // entry 3: stall
    vecs[3]  = mk(0, 1, 5,  1, 0,  0, 6, 1, 0, 1, 0, 1); // entry 2: stall
    vecs[4]  = mk(0, 1, 5,  1, 0,  0, 6, 1, 0, 0, 1, 1); // entry 1: write-first, issue
    vecs[5]  = mk(0, 1, 0,  0, 6,  1, 0, 1, 0, 1, 0, 1); // rs2 hazard on x6
    vecs[6]  = mk(0, 1, 0,  0, 6,  1, 0, 1, 1, 2, 0, 1); // redirect beats data
    vecs[7]  = mk(0, 1, 0,  0, 6,  1, 0, 1, 0, 0, 1, 1); // 1-cycle flush over, issue
    vecs[8]  = mk(0, 1, 0,  1, 0,  1, 0, 1, 0, 0, 1, 0); // x0 reader, rd=0 not tracked
    vecs[9]  = mk(0, 0, 0,  0, 0,  0, 7, 1, 0, 0, 0, 0); // invalid: no issue, no load
    vecs[10] = mk(0, 1, 7,  1, 0,  0, 8, 1, 0, 0, 1, 0); // x7 free; loads x8
    vecs[11] = mk(0, 1, 8,  1, 8,  1, 0, 0, 0, 1, 0, 1); // stall on x8
    vecs[12] = mk(1, 1, 8,  1, 8,  1, 0, 0, 0, 0, 0, 0); // reset mid-stall
    vecs[13] = mk(0, 1, 8,  1, 8,  1, 0, 0, 0, 0, 1, 0); // issues right after reset
    vecs[14] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 2, 0, 0); // bare redirect
    vecs[15] = mk(0, 1, 3,  1, 0,  0, 3, 1, 1, 2, 0, 0); // redirect kills issue+load
    vecs[16] = mk(0, 1, 3,  1, 0,  0, 0, 0, 0, 0, 1, 0); // x3 never loaded

    adv();
    adv();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
            vecs[i].rd, vecs[i].wren, vecs[i].redir);
      #4;
      chk("tbl_op", i, 32'(op0), 32'(vecs[i].op));
      chk("tbl_issue", i, 32'(iss0), 32'(vecs[i].issue));
      chk("tbl_busy", i, 32'(busy0), 32'(vecs[i].busy));
      adv();
    end

    // Back-to-back RAW: default issues at t3, RF_WR_FIRST=0 issues at t4.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 1, 1, 1, 0, 0, 5, 1, 0); #4;
    chk("raw_t0_issue1", 0, 32'(iss1), 1);
    adv();
    for (int t = 1; t <= 4; t++) begin
      drive(0, 1, 5, 1, 0, 0, 0, 0, 0); #4;
      chk("raw_wf0_op", t, 32'(op1), (t <= 3) ? 32'd1 : 32'd0);
      chk("raw_wf0_issue", t, 32'(iss1), (t == 4) ? 32'd1 : 32'd0);
      if (t <= 3) chk("raw_def_op", t, 32'(op0), (t <= 2) ? 32'd1 : 32'd0);
      adv();
    end
    for (int t = 5; t <= 6; t++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #4;
      chk("redir_op1", t, 32'(op1), 2);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #4;
`ifdef HAZARD_STALL_STATS_EN
    chk("data_stall_cnt", 0, dcnt1, 3);
    chk("ctrl_stall_cnt", 0, ccnt1, 2);
`endif
    adv();

    // Redirect during a data stall with a two-cycle flush.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); adv();
    drive(0, 1, 1, 1, 0, 0, 5, 1, 0); adv();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0); #4;
    chk("fl2_t1_op", 1, 32'(op2), 1);
    adv();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 1); #4;
    chk("fl2_t2_op", 2, 32'(op2), 2);
    chk("fl2_t2_issue", 2, 32'(iss2), 0);
    adv();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0); #4;
    chk("fl2_t3_op", 3, 32'(op2), 2);
    chk("fl2_t3_issue", 3, 32'(iss2), 0);
    adv();
    drive(0, 1, 5, 1, 0, 0, 0, 0, 0); #4;
    chk("fl2_t4_op", 4, 32'(op2), 0);
    chk("fl2_t4_issue", 4, 32'(iss2), 1);
    adv();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
